// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// alu_issue_arbiter : two-port ALU issue arbiter, one-deep issue register,
//                     port-0 priority with a port-1 starvation guard.
// Optional macro ALU_ARB_PERF_EN adds saturating grant/conflict counters.
// Revision 1.0
// ============================================================================
module alu_issue_arbiter #(
  parameter int PAYLOAD_W    = 160,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [PAYLOAD_W-1:0] req0_payload,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [PAYLOAD_W-1:0] req1_payload,
  output logic                 issue_valid,
  output logic [PAYLOAD_W-1:0] issue_payload,
`ifdef ALU_ARB_PERF_EN
  output logic [31:0]          grant0_cnt,
  output logic [31:0]          grant1_cnt,
  output logic [31:0]          conflict_cnt,
`endif
  output logic                 issue_src
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 src_q, src_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 accept_ok;
  logic                 pick1;
  logic                 grant0;
  logic                 grant1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      payload_q <= '0;
      src_q     <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      src_q     <= src_d;
      starve_q  <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    src_d     = src_q;
    starve_d  = starve_q;

    // rst is folded in so ready is low for the whole time reset is held.
    accept_ok = rst && !flush && !stall && (state_q != ST_RECOVER);
    pick1     = req1_valid && (!req0_valid || (starve_q == C_STARVE_MAX));
    grant1    = accept_ok && pick1;
    grant0    = accept_ok && req0_valid && !pick1;

    case (state_q)
      ST_EMPTY: begin
        if (grant0 || grant1) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (!stall) state_d = (grant0 || grant1) ? ST_FULL : ST_EMPTY;
      end
      ST_RECOVER: state_d = ST_EMPTY;
      default:    state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_RECOVER;

    if (grant0) begin
      payload_d = req0_payload;
      src_d     = 1'b0;
    end else if (grant1) begin
      payload_d = req1_payload;
      src_d     = 1'b1;
    end

    if (!req1_valid || grant1) begin
      starve_d = '0;
    end else if (grant0 && (starve_q != C_STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  assign req0_ready    = grant0;
  assign req1_ready    = grant1;
  assign issue_valid   = (state_q == ST_FULL);
  assign issue_payload = payload_q;
  assign issue_src     = src_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant0_cnt_q, grant0_cnt_d;
  logic [31:0] grant1_cnt_q, grant1_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant0_cnt_q   <= '0;
      grant1_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant0_cnt_q   <= grant0_cnt_d;
      grant1_cnt_q   <= grant1_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  always_comb begin
    grant0_cnt_d   = grant0_cnt_q;
    grant1_cnt_d   = grant1_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant0 && (grant0_cnt_q != 32'hFFFF_FFFF)) grant0_cnt_d = grant0_cnt_q + 32'd1;
    if (grant1 && (grant1_cnt_q != 32'hFFFF_FFFF)) grant1_cnt_d = grant1_cnt_q + 32'd1;
    if (req0_valid && req1_valid && (grant0 || grant1) &&
        (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  assign grant0_cnt   = grant0_cnt_q;
  assign grant1_cnt   = grant1_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_arbiter : directed self-checking bench for alu_issue_arbiter.
// Revision 1.0
// ============================================================================
module tb_alu_issue_arbiter;

  localparam int PAYLOAD_W = 160;

  logic                 clk;
  logic                 rst;
  logic                 stall;
  logic                 flush;
  logic                 req0_valid;
  logic                 req0_ready;
  logic [PAYLOAD_W-1:0] req0_payload;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [PAYLOAD_W-1:0] req1_payload;
  logic                 issue_valid;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic                 issue_src;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]          grant0_cnt;
  logic [31:0]          grant1_cnt;
  logic [31:0]          conflict_cnt;
`endif

  int n_checks;
  int n_fails;

  alu_issue_arbiter #(
    .PAYLOAD_W   (PAYLOAD_W),
    .STARVE_LIMIT(4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_payload (req0_payload),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_payload (req1_payload),
    .issue_valid  (issue_valid),
    .issue_payload(issue_payload),
`ifdef ALU_ARB_PERF_EN
    .grant0_cnt   (grant0_cnt),
    .grant1_cnt   (grant1_cnt),
    .conflict_cnt (conflict_cnt),
`endif
    .issue_src    (issue_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both ports valid for ten cycles from a cleared starve counter.
  task automatic both_valid_burst(input string tag);
    logic [9:0] exp_g;
    logic [PAYLOAD_W-1:0] p0;
    logic [PAYLOAD_W-1:0] p1;
    exp_g = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      p0 = {32'h1000_0000 + 32'(i), 128'h11};
      p1 = {32'h2000_0000 + 32'(i), 128'h22};
      req0_valid   = 1'b1;
      req1_valid   = 1'b1;
      req0_payload = p0;
      req1_payload = p1;
      #1;
      check_eq({tag, "_ready1"}, req1_ready, exp_g[i]);
      check_eq({tag, "_ready0"}, req0_ready, !exp_g[i]);
      tick();
      check_eq({tag, "_valid"}, issue_valid, 1'b1);
      check_eq({tag, "_src"}, issue_src, exp_g[i]);
      check_eq({tag, "_payload"}, issue_payload, exp_g[i] ? p1 : p0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    req0_valid   = 1'b1;
    req1_valid   = 1'b1;
    req0_payload = 160'h55;
    req1_payload = 160'h66;

    // Reset state, with both requesters valid
    tick();
    tick();
    check_eq("rst_valid", issue_valid, 1'b0);
    check_eq("rst_src", issue_src, 1'b0);
    check_eq("rst_payload", issue_payload, 160'h0);
    check_eq("rst_ready0", req0_ready, 1'b0);
    check_eq("rst_ready1", req1_ready, 1'b0);

    // Single port-0 transfer, one-cycle load latency
    rst          = 1'b1;
    req1_valid   = 1'b0;
    req0_payload = 160'h11;
    #1;
    check_eq("first_ready0", req0_ready, 1'b1);
    check_eq("first_ready1", req1_ready, 1'b0);
    tick();
    check_eq("first_valid", issue_valid, 1'b1);
    check_eq("first_payload", issue_payload, 160'h11);
    check_eq("first_src", issue_src, 1'b0);

    // Starvation guard: 0,0,0,0,1,0,0,0,0,1
    both_valid_burst("starve");

    // Stall holds the issue register
    req1_valid   = 1'b0;
    req0_payload = 160'hAB;
    #1;
    check_eq("ld_ab_ready0", req0_ready, 1'b1);
    tick();
    check_eq("ld_ab_payload", issue_payload, 160'hAB);
    stall        = 1'b1;
    req0_payload = 160'hCD;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("stall_ready0", req0_ready, 1'b0);
      check_eq("stall_ready1", req1_ready, 1'b0);
      tick();
      check_eq("stall_payload", issue_payload, 160'hAB);
      check_eq("stall_valid", issue_valid, 1'b1);
      check_eq("stall_src", issue_src, 1'b0);
    end
    stall = 1'b0;
    #1;
    check_eq("unstall_ready0", req0_ready, 1'b1);
    tick();
    check_eq("unstall_payload", issue_payload, 160'hCD);

    // Flush beats stall and grants, then one RECOVER bubble
    flush      = 1'b1;
    stall      = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_eq("flush_ready0", req0_ready, 1'b0);
    check_eq("flush_ready1", req1_ready, 1'b0);
    tick();
    check_eq("flush_valid", issue_valid, 1'b0);
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check_eq("recover_ready0", req0_ready, 1'b0);
    check_eq("recover_ready1", req1_ready, 1'b0);
    tick();
    check_eq("recover_valid", issue_valid, 1'b0);
    req0_payload = 160'hE1;
    #1;
    check_eq("resume_ready0", req0_ready, 1'b1);
    tick();
    check_eq("resume_valid", issue_valid, 1'b1);
    check_eq("resume_payload", issue_payload, 160'hE1);

    // Starve counter now 1; three more port-0 grants take it to the limit
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("prefill_ready0", req0_ready, 1'b1);
      tick();
    end
    #1;
    check_eq("limit_ready1", req1_ready, 1'b1);

    // Asynchronous reset mid-cycle
    rst = 1'b0;
    #1;
    check_eq("async_valid", issue_valid, 1'b0);
    check_eq("async_payload", issue_payload, 160'h0);
    check_eq("async_ready0", req0_ready, 1'b0);
    check_eq("async_ready1", req1_ready, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("post_rst_ready0", req0_ready, 1'b1);
    check_eq("post_rst_ready1", req1_ready, 1'b0);

    both_valid_burst("post_rst");
`ifdef ALU_ARB_PERF_EN
    check_eq("perf_g0", grant0_cnt, 32'd8);
    check_eq("perf_g1", grant1_cnt, 32'd2);
    check_eq("perf_conflict", conflict_cnt, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter PAYLOAD_W, default 160, width of the packed ALU dispatch payload passed through unmodified.
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive port-0 grants allowed while port 1 waits.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 stall  in  1  core stall; ALU holds its input this cycle.
REQ-007 flush  in  1  core flush; kill the issue register and block acceptance.
REQ-008 req0_valid / req0_ready / req0_payload  in / out / PAYLOAD_W  requester 0 (primary dispatcher) handshake.
REQ-009 req1_valid / req1_ready / req1_payload  in / out / PAYLOAD_W  requester 1 (secondary issue source) handshake.
REQ-010 issue_valid  out  1  issue register holds a live op for the ALU.
REQ-011 issue_payload  out  PAYLOAD_W  op presented to the ALU.
REQ-012 issue_src  out  1  requester index of the op in issue_payload.

Function
REQ-013 Transfer on a port SHALL occur when reqN_valid and reqN_ready are both 1 at a rising edge; at most one port SHALL be ready per cycle.
REQ-014 ready SHALL depend only on state, stall, flush, both valids and the starve counter; never on the ready outputs.
REQ-015 FSM states: EMPTY (issue_valid=0), FULL (issue_valid=1), RECOVER (one bubble after flush).
REQ-016 EMPTY: if !stall and !flush and a valid request exists, grant it, load issue register, go FULL; else stay.
REQ-017 FULL: if !stall, the held op is consumed; simultaneously grant and load a new op (stay FULL) or go EMPTY if none; if stall, hold payload, all ready=0.
REQ-018 Any state, flush=1: all ready=0, issue_valid cleared next edge, go RECOVER; flush has priority over stall and new grants.
REQ-019 RECOVER: all ready=0 for exactly one cycle, then EMPTY; flush during RECOVER stays RECOVER.
REQ-020 Arbitration: fixed priority to port 0, except when starve counter equals STARVE_LIMIT and req1_valid=1, port 1 wins.
REQ-021 Starve counter: increments on a port-0 grant while req1_valid=1; clears on any port-1 grant or when req1_valid=0; saturates at STARVE_LIMIT; unaffected by flush.
REQ-022 Load latency: an op accepted at edge N SHALL appear on issue_payload/issue_valid after edge N (one cycle); no combinational path from reqN_payload to issue_payload.
REQ-023 issue_src SHALL update with issue_payload and hold under stall.

Reset
REQ-024 rst=0 SHALL immediately force state EMPTY, issue_valid=0, issue_src=0, issue_payload=0, starve counter=0, all ready=0.
REQ-025 Reset asserted mid-transfer SHALL discard the held op; first grant possible on the first edge after rst deasserts.

Configuration
REQ-026 Macro ALU_ARB_PERF_EN defined: add outputs grant0_cnt, grant1_cnt, conflict_cnt (32 bits each) counting port-0 grants, port-1 grants and cycles with both valid and one granted; saturating at 32'hFFFF_FFFF; reset to 0; not cleared by flush.
REQ-027 ALU_ARB_PERF_EN undefined: these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset, then req0_valid=1 payload 0x...0011, stall=0 -> req0_ready=1, next cycle issue_valid=1, issue_payload=0x...0011, issue_src=0.
REQ-029 Both valid continuously, STARVE_LIMIT=4, no stall -> grant sequence 0,0,0,0,1,0,0,0,0,1; issue_src follows one cycle later.
REQ-030 FULL with payload 0xAB, stall=1 for 3 cycles while req0_valid=1 -> both ready=0, issue_payload stays 0xAB, issue_valid=1 throughout.
REQ-031 FULL, flush=1 together with stall=1 and both valid -> no ready, issue_valid=0 next cycle, one RECOVER bubble, grant resumes in the following cycle.
REQ-032 Drop rst mid-stream with issue_valid=1 -> issue_valid=0 without waiting for clk edge; starve counter 0 after release.
REQ-033 With ALU_ARB_PERF_EN, 10 cycles both valid, STARVE_LIMIT=4 -> grant0_cnt=8, grant1_cnt=2, conflict_cnt=10.
